// File: rtl/adder_tree_pkg.sv
// Shared types and constants for the 8-lane adder tree and its feeder.
// Latency: n/a (declarations only). Backpressure: n/a.
// Contents: operand/sum widths, lane count, operand_t, sum_t, feeder_state_t.
package adder_tree_pkg;

  localparam int ADDER_WIDTH = 28;
  localparam int LANES       = 8;
  // Three extra bits make an 8-operand unsigned sum exact.
  localparam int SUM_WIDTH   = ADDER_WIDTH + 3;
  localparam int CNT_WIDTH   = 3;
  localparam int TAG_WIDTH   = 4;

  typedef logic [ADDER_WIDTH-1:0] operand_t;
  typedef logic [SUM_WIDTH-1:0]   sum_t;

  typedef enum logic {
    FILL  = 1'b0,
    ISSUE = 1'b1
  } feeder_state_t;

endpackage

// File: rtl/adder_tree_latency_pipe.sv
// Valid/tag shift register that tracks issued frames through the tree latency.
// Latency: DEPTH edges from in_vld to out_vld; tap is one stage earlier. No backpressure.
// Ports: clk, rst (async high), in_vld/in_tag in; tap_vld, out_vld, out_tag out.
module adder_tree_latency_pipe #(
  parameter int DEPTH = 3,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic [TAG_W-1:0] in_tag,
  output logic             tap_vld,
  output logic             out_vld,
  output logic [TAG_W-1:0] out_tag
);

  logic [DEPTH-1:0] vld_q;
  logic [TAG_W-1:0] tag_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      vld_q <= {vld_q[DEPTH-2:0], in_vld};
      // Tags only advance alongside a valid flag, so the last stage holds
      // the most recent frame's tag until the next one arrives.
      if (in_vld) begin
        tag_q[0] <= in_tag;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (vld_q[i-1]) begin
          tag_q[i] <= tag_q[i-1];
        end
      end
    end
  end

  assign tap_vld = vld_q[DEPTH-2];
  assign out_vld = vld_q[DEPTH-1];
  assign out_tag = tag_q[DEPTH-1];

endmodule

// File: rtl/adder_tree_feeder.sv
// Packs a serial operand stream into an 8-lane bank, issues it to the adder tree, returns the sum.
// Latency: result pulse TREE_LATENCY+1 cycles after issue. Backpressure: in_ready drops for the one ISSUE cycle per frame.
// Ports: in_valid/in_ready/in_data/in_last stream in; lanes/issue to tree; sum_in from tree; res_valid/res_data/res_lanes out.
module adder_tree_feeder
  import adder_tree_pkg::*;
#(
  parameter int TREE_LATENCY = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [ADDER_WIDTH-1:0]       in_data,
  input  logic                         in_last,
  output logic [LANES*ADDER_WIDTH-1:0] lanes,
  output logic                         issue,
  input  logic [SUM_WIDTH-1:0]         sum_in,
  output logic                         res_valid,
  output logic [SUM_WIDTH-1:0]         res_data,
  output logic [TAG_WIDTH-1:0]         res_lanes
);

  // Results must drain before the next frame can issue (9-cycle minimum
  // frame period), and the counter/tree shape assumes exactly 8 lanes.
  if (TREE_LATENCY < 1 || TREE_LATENCY + 1 >= 9 || LANES != 8) begin : g_bad_cfg
    $error("adder_tree_feeder: unsupported TREE_LATENCY/LANES configuration");
  end

  feeder_state_t state_q, state_d;

  logic [CNT_WIDTH-1:0]         cnt_q;
  operand_t                     fill_bank [LANES];
  logic [LANES*ADDER_WIDTH-1:0] merged;
  logic [TAG_WIDTH-1:0]         frame_cnt_q;
  logic                         xfer;
  logic                         close;
  logic                         tap_vld;

  assign xfer  = in_valid && (state_q == FILL);
  assign close = xfer && ((cnt_q == CNT_WIDTH'(LANES - 1)) || in_last);

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state and handshake outputs
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    issue    = 1'b0;
    case (state_q)
      FILL: begin
        in_ready = 1'b1;
        if (close) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        issue   = 1'b1;
        state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  // Closing bank: earlier lanes from the fill bank, the current word in its
  // slot, everything above forced to zero.
  always_comb begin
    merged = '0;
    for (int k = 0; k < LANES; k++) begin
      if (CNT_WIDTH'(k) < cnt_q) begin
        merged[k*ADDER_WIDTH +: ADDER_WIDTH] = fill_bank[k];
      end else if (CNT_WIDTH'(k) == cnt_q) begin
        merged[k*ADDER_WIDTH +: ADDER_WIDTH] = in_data;
      end
    end
  end

  // Fill bank, lane counter and the bank presented to the tree. lanes only
  // moves on the close edge so the tree always sees a coherent frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      lanes       <= '0;
      frame_cnt_q <= '0;
      for (int k = 0; k < LANES; k++) begin
        fill_bank[k] <= '0;
      end
    end else if (xfer) begin
      if (close) begin
        lanes       <= merged;
        frame_cnt_q <= {1'b0, cnt_q} + TAG_WIDTH'(1);
        cnt_q       <= '0;
        for (int k = 0; k < LANES; k++) begin
          fill_bank[k] <= '0;
        end
      end else begin
        fill_bank[cnt_q] <= in_data;
        cnt_q            <= cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  adder_tree_latency_pipe #(
    .DEPTH (TREE_LATENCY + 1),
    .TAG_W (TAG_WIDTH)
  ) u_pipe (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (issue),
    .in_tag  (frame_cnt_q),
    .tap_vld (tap_vld),
    .out_vld (res_valid),
    .out_tag (res_lanes)
  );

  // The tap stage marks the last cycle sum_in belongs to this frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_data <= '0;
    end else if (tap_vld) begin
      res_data <= sum_in;
    end
  end

endmodule

// File: tb/tb_adder_tree_feeder.sv
module tb_adder_tree_feeder;
  import adder_tree_pkg::*;

  logic                         clk = 1'b0;
  logic                         rst = 1'b1;
  logic                         in_valid = 1'b0;
  logic                         in_ready;
  logic [ADDER_WIDTH-1:0]       in_data = '0;
  logic                         in_last = 1'b0;
  logic [LANES*ADDER_WIDTH-1:0] lanes;
  logic                         issue;
  logic [SUM_WIDTH-1:0]         sum_in;
  logic                         res_valid;
  logic [SUM_WIDTH-1:0]         res_data;
  logic [TAG_WIDTH-1:0]         res_lanes;

  always #5 clk = ~clk;

  adder_tree_feeder #(.TREE_LATENCY(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .lanes     (lanes),
    .issue     (issue),
    .sum_in    (sum_in),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_lanes (res_lanes)
  );

  // Two-edge registered 8-way adder model.
  logic [LANES*ADDER_WIDTH-1:0] lanes_r = '0;
  logic [SUM_WIDTH-1:0]         sum_r = '0;

  function automatic logic [SUM_WIDTH-1:0] tree_sum(input logic [LANES*ADDER_WIDTH-1:0] b);
    logic [SUM_WIDTH-1:0] s;
    s = '0;
    for (int k = 0; k < LANES; k++) s = s + SUM_WIDTH'(b[k*ADDER_WIDTH +: ADDER_WIDTH]);
    return s;
  endfunction

  always @(posedge clk) begin
    lanes_r <= lanes;
    sum_r   <= tree_sum(lanes_r);
  end
  assign sum_in = sum_r;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: {res_lanes, res_data} expectations, plus issue timestamps.
  logic [TAG_WIDTH+SUM_WIDTH-1:0] exp_q[$];
  int                             iss_q[$];
  logic [TAG_WIDTH+SUM_WIDTH-1:0] e;
  int                             t_iss;

  task automatic expect_result(input logic [SUM_WIDTH-1:0] d, input logic [TAG_WIDTH-1:0] n);
    exp_q.push_back({n, d});
  endtask

  always @(negedge clk) begin
    if (rst) begin
      iss_q.delete();
    end else begin
      if (issue) iss_q.push_back(cyc);
      if (res_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got data 0x%0h lanes %0d, expected no result", res_data, res_lanes);
        end else begin
          e = exp_q.pop_front();
          check("res_data", 256'(res_data), 256'(e[SUM_WIDTH-1:0]));
          check("res_lanes", 256'(res_lanes), 256'(e[TAG_WIDTH+SUM_WIDTH-1:SUM_WIDTH]));
        end
        if (iss_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL result_without_issue: got res_valid at cycle %0d, expected a prior issue", cyc);
        end else begin
          t_iss = iss_q.pop_front();
          check("issue_to_result_latency", 256'(cyc - t_iss), 256'(3));
        end
      end
    end
  end

  // Drive one word and hold it until a transfer edge; in_ready is sampled mid-cycle.
  task automatic send(input logic [ADDER_WIDTH-1:0] d, input logic last);
    logic ok;
    int   n;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 20) begin
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 for %0d cycles, expected acceptance", n);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_seq(input int first, input int n, input logic last_on_end, input logic gap);
    for (int i = 0; i < n; i++) begin
      if (gap) idle(1);
      send(ADDER_WIDTH'(first + i), last_on_end && (i == n - 1));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LANES*ADDER_WIDTH-1:0] exp_lanes;
    int t1;
    int t2;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_issue", 256'(issue), 256'(0));
    check("reset_res_valid", 256'(res_valid), 256'(0));
    check("reset_res_data", 256'(res_data), 256'(0));
    check("reset_res_lanes", 256'(res_lanes), 256'(0));
    check("reset_lanes", 256'(lanes), 256'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("ready_after_reset", 256'(in_ready), 256'(1));

    // Full frame 1..8, then max operands back-to-back
    expect_result(31'd36, 4'd8);
    send_seq(1, 8, 1'b0, 1'b0);
    t1 = cyc;
    check("issue_pulse", 256'(issue), 256'(1));
    check("ready_low_in_issue", 256'(in_ready), 256'(0));
    expect_result(31'h7FFF_FFF8, 4'd8);
    for (int i = 0; i < 8; i++) send(28'hFFF_FFFF, 1'b0);
    t2 = cyc;
    check("frame_period", 256'(t2 - t1), 256'(9));
    check("issue_single_cycle", 256'(issue), 256'(1));
    @(posedge clk);
    #1;
    check("issue_deasserts", 256'(issue), 256'(0));
    check("ready_back_high", 256'(in_ready), 256'(1));

    // Partial frame 5,6,7 then single-word frame
    expect_result(31'd18, 4'd3);
    send(28'd5, 1'b0);
    send(28'd6, 1'b0);
    send(28'd7, 1'b1);
    exp_lanes = '0;
    exp_lanes[0*ADDER_WIDTH +: ADDER_WIDTH] = 28'd5;
    exp_lanes[1*ADDER_WIDTH +: ADDER_WIDTH] = 28'd6;
    exp_lanes[2*ADDER_WIDTH +: ADDER_WIDTH] = 28'd7;
    check("partial_lanes", 256'(lanes), 256'(exp_lanes));
    expect_result(31'd9, 4'd1);
    send(28'd9, 1'b1);
    exp_lanes = '0;
    exp_lanes[0 +: ADDER_WIDTH] = 28'd9;
    check("single_lane_bank", 256'(lanes), 256'(exp_lanes));
    idle(6);

    // Stalled stream: valid every other cycle; second frame ends with in_last at cnt 7
    expect_result(31'd36, 4'd8);
    send_seq(1, 8, 1'b0, 1'b1);
    expect_result(31'd108, 4'd8);
    send_seq(10, 8, 1'b1, 1'b1);
    idle(6);

    // Reset after 4 words: partial frame discarded
    send_seq(1, 4, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check("async_reset_lanes_clear", 256'(lanes), 256'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    // Reset one cycle after an issue: in-flight result dropped
    send_seq(1, 8, 1'b0, 1'b0);
    check("issue_before_reset", 256'(issue), 256'(1));
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("lanes_after_reset", 256'(lanes), 256'(0));
    expect_result(31'd36, 4'd8);
    send_seq(1, 8, 1'b0, 1'b0);
    idle(6);

    // Word offered during ISSUE must be ignored
    expect_result(31'd10, 4'd4);
    send_seq(1, 4, 1'b1, 1'b0);
    in_valid = 1'b1;
    in_data  = 28'hABC_DEF;
    in_last  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    expect_result(31'd5, 4'd2);
    send(28'd2, 1'b0);
    send(28'd3, 1'b1);

    idle(10);
    check("scoreboard_drained", 256'(exp_q.size()), 256'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_tree_feeder.md
Name: adder_tree_feeder

Overview:
Producer side of the 8-lane adder tree. It accepts a serial stream of ADDER_WIDTH-bit operands over a valid/ready handshake and packs them into an 8-lane parallel bank. It then issues the bank to the registered adder tree and captures the tree's full-width sum after the fixed tree latency. The result is returned as a one-cycle result pulse tagged with the number of real lanes in the frame. It sits between a streaming source and the adder tree.

Parameters:
ADDER_WIDTH, 28, operand width in bits
LANES, 8, lanes per frame; fixed at 8 (3-level tree)
TREE_LATENCY, 2, clock edges from lanes changing to sum_in valid (input register plus output register)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand valid
in_ready  output  1  feeder can accept an operand
in_data  input  ADDER_WIDTH  operand
in_last  input  1  final operand of a frame; the frame closes early
lanes  output  LANES*ADDER_WIDTH  operand bank to the tree; lane k = bits [k*W +: W], lane 0 = first word
issue  output  1  one-cycle pulse: lanes hold a new frame this cycle
sum_in  input  ADDER_WIDTH+3  full-width tree sum
res_valid  output  1  one-cycle result pulse
res_data  output  ADDER_WIDTH+3  captured frame sum
res_lanes  output  4  real operand count of the frame, 1..8

Behaviour:
- Reset (asynchronous, any time): state goes to FILL, lane counter to 0, fill bank to 0, lanes to 0. issue, res_valid, res_data and res_lanes go to 0; in_ready goes to 1 after deassertion. The latency pipe is cleared, so in-flight results are dropped and never reported.
- A transfer occurs on a rising edge with in_valid && in_ready. in_data, in_last and in_valid are ignored when in_ready = 0.
- FILL state: in_ready = 1. Each transfer writes fill_bank[cnt] and increments cnt.
  - If the transfer is at cnt == 7, or in_last = 1, the frame closes on that edge:
    - lanes <= fill bank with the just-accepted word merged in; unfilled lanes are forced to 0.
    - frame count = cnt+1 is stored.
    - the fill bank and cnt are cleared.
    - state goes to ISSUE.
- ISSUE state: lasts exactly one cycle. issue = 1, in_ready = 0 (one bubble per frame). Next state is always FILL.
- lanes changes only on the frame-close edge and otherwise stays stable. The tree therefore samples a coherent bank.
- Latency pipe: a TREE_LATENCY+1 stage flag shift register, fed by issue, carries the frame count alongside.
  - If issue is high in cycle N, sum_in is sampled at the end of cycle N+TREE_LATENCY.
  - res_valid = 1 in cycle N+TREE_LATENCY+1, with res_data equal to that sample and res_lanes equal to the frame count.
  - res_data and res_lanes hold until the next result. res_valid is high for one cycle only.
- Throughput: at most one frame per 9 cycles. Results never overlap because TREE_LATENCY+1 < 9; a build-time check requires this.
- Widths: res_data is ADDER_WIDTH+3 bits and exact for 8 lanes. There is no truncation or saturation. Operands are unsigned.
- in_last on the first word gives a 1-lane frame, with lanes 1..7 = 0 and res_lanes = 1.
- in_last at cnt == 7 behaves the same as a plain 8th word.
- No empty frames exist. in_last without in_valid is ignored.
- There is no downstream ready. The result consumer must take res_valid when it pulses.

Decomposition:
- Shared package adder_tree_pkg holds:
  - ADDER_WIDTH and LANES constants
  - SUM_WIDTH = ADDER_WIDTH+3
  - typedef operand_t, logic [ADDER_WIDTH-1:0]
  - typedef sum_t, logic [SUM_WIDTH-1:0]
  - enum feeder_state_t {FILL, ISSUE}
- One sub-module, adder_tree_latency_pipe: a parameterised-depth valid/tag shift register with async clear. The FSM and bank stay in the top module.

Test Plan:
- Bench setup: a 2-edge registered 8-way adder model drives sum_in.
- Full frame: words 1..8 back-to-back -> issue pulses once; res_valid 3 cycles after issue with res_data = 36, res_lanes = 8; in_ready low exactly 1 cycle.
- Max operands: eight words of 0xFFFFFFF -> res_data = 0x7FFFFFF8, with no truncation.
- Partial frame: 5, 6, 7 with in_last on 7 -> lanes 3..7 = 0; res_data = 18, res_lanes = 3. Then a single word 9 with in_last -> res_data = 9, res_lanes = 1.
- Stall/throughput: in_valid toggling every other cycle across two frames of 1..8 and 10..17 -> res_data = 36, then 108. With continuous valid, frames issue every 9 cycles.
- Reset mid-operation: assert rst after 4 words, and again one cycle after an issue -> no res_valid for those frames; a following 1..8 frame yields 36.
- Ignored input: in_valid high with in_ready low during ISSUE, carrying 0xABCDEF -> the word is not captured, and the next frame's sum excludes it.
